// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// master = loader side, slave = byte source / memory / CPU side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream program loader: HEADER, N, 4*N little-endian data bytes, CHK.
// Writes words from address 0 and keeps the CPU in reset until a frame checks out.
module imem_boot_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  imem_boot_loader_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;

  logic              rx_ready;
  logic              accept;
  logic [ADDR_W-1:0] last_word;

  // Busy only during the write cycle, so a pending byte simply waits one cycle.
  assign rx_ready  = ~imem_we_q;
  assign accept    = bus.rx_valid && rx_ready;
  // A count of 0 means 256 words; the subtraction wraps to 0xFF naturally.
  assign last_word = ADDR_W'(n_q - 8'd1);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      checksum_q   <= '0;
      word_buf_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      byte_idx_q   <= byte_idx_d;
      checksum_q   <= checksum_d;
      word_buf_q   <= word_buf_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    byte_idx_d   = byte_idx_q;
    checksum_d   = checksum_q;
    word_buf_d   = word_buf_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;

    if (accept) begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (bus.rx_data == HEADER) begin
            state_d     = COUNT;
            cpu_reset_d = 1'b1;
          end
        end
        COUNT: begin
          state_d    = DATA;
          n_d        = bus.rx_data;
          word_cnt_d = '0;
          byte_idx_d = '0;
          checksum_d = '0;
        end
        DATA: begin
          checksum_d = checksum_q + bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q;
            imem_wdata_d = {bus.rx_data, word_buf_q};
            word_cnt_d   = word_cnt_q + 1'b1;
            if (word_cnt_q == last_word) begin
              state_d = CHECK;
            end
          end else begin
            // Bytes shift in from the top so the first byte ends up in bits 7:0.
            word_buf_d = {bus.rx_data, word_buf_q[23:8]};
          end
        end
        CHECK: begin
          if (bus.rx_data == checksum_q) begin
            state_d     = DONE;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ERROR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.done       = (state_q == DONE);
  assign bus.error      = (state_q == ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed plus randomized frames for the boot loader, checked against a
// frame-level model (expected write list and checksum verdict per frame).
module tb_imem_boot_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  imem_boot_loader_if #(.ADDR_W(8)) bus ();

  imem_boot_loader #(.ADDR_W(8), .HEADER(8'hA5)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] fw[$];
  logic [7:0]  bq[$];
  logic        prev_we = 1'b0;
  bit          gaps_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      got_addr.push_back(bus.imem_addr);
      got_data.push_back(bus.imem_wdata);
      check("we_back_to_back", {31'd0, prev_we}, 32'd0);
    end
    prev_we <= (bus.imem_we === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send_queue();
    foreach (bq[i]) send_byte(bq[i]);
  endtask

  // Model: words go to addresses 0..n-1 in order; CHK is the byte sum mod 256.
  task automatic send_frame(input int nwords, input bit bad_chk);
    int sum = 0;
    logic [7:0] chk;
    logic [31:0] w;
    send_byte(8'hA5);
    send_byte(8'(nwords));
    for (int i = 0; i < nwords; i++) begin
      w = fw[i];
      exp_addr.push_back(8'(i));
      exp_data.push_back(w);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[7:0]);
        sum += int'(w[7:0]);
        w = w >> 8;
      end
    end
    chk = 8'(sum % 256);
    if (bad_chk) chk = chk + 8'(1 + $urandom_range(0, 254));
    send_byte(chk);
    check("frame_done", {31'd0, bus.done}, {31'd0, !bad_chk});
    check("frame_error", {31'd0, bus.error}, {31'd0, bad_chk});
    check("frame_cpu_reset", {31'd0, bus.cpu_reset}, {31'd0, bad_chk});
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_count"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, {24'd0, got_addr[i]}, {24'd0, exp_addr[i]});
      check({tag, "_data"}, got_data[i], exp_data[i]);
    end
    got_addr.delete(); got_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, {31'd0, bus.cpu_reset}, 32'd1);
    check({tag, "_imem_we"},   {31'd0, bus.imem_we},   32'd0);
    check({tag, "_imem_addr"}, {24'd0, bus.imem_addr}, 32'd0);
    check({tag, "_imem_wdata"}, bus.imem_wdata,         32'd0);
    check({tag, "_done"},      {31'd0, bus.done},      32'd0);
    check({tag, "_error"},     {31'd0, bus.error},     32'd0);
    check({tag, "_rx_ready"},  {31'd0, bus.rx_ready},  32'd1);
  endtask

  task automatic push_test2_expect();
    exp_addr.push_back(8'h00); exp_data.push_back(32'hE3A00013);
    exp_addr.push_back(8'h01); exp_data.push_back(32'hE2811001);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Test 1: reset values while held in reset, mid-cycle.
    #23;
    check_reset_vals("t1_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("t1_after_release");

    // Test 2: reference frame.
    bq = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2, 8'h0A};
    push_test2_expect();
    send_queue();
    check("t2_done", {31'd0, bus.done}, 32'd1);
    check("t2_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
    check("t2_error", {31'd0, bus.error}, 32'd0);
    check_writes("t2");

    // Asynchronous reset asserted mid-cycle takes effect immediately.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t1_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Test 3: bad checksum, then the good frame again.
    bq[10] = 8'h0B;
    push_test2_expect();
    send_queue();
    check("t3_error", {31'd0, bus.error}, 32'd1);
    check("t3_done", {31'd0, bus.done}, 32'd0);
    check("t3_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    bq[10] = 8'h0A;
    push_test2_expect();
    send_queue();
    check("t3_redo_done", {31'd0, bus.done}, 32'd1);
    check("t3_redo_error", {31'd0, bus.error}, 32'd0);
    check("t3_redo_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
    check_writes("t3");

    // Test 4: garbage ahead of the header is dropped.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    push_test2_expect();
    send_queue();
    check("t4_done", {31'd0, bus.done}, 32'd1);
    check("t4_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
    check_writes("t4");

    // Test 5: N=0 means 256 words, word k = k.
    fw.delete();
    for (int k = 0; k < 256; k++) fw.push_back(32'(k));
    send_frame(256, 1'b0);
    repeat (10) @(negedge clk);
    check_writes("t5");

    // Test 6: random frames with random gaps.
    gaps_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 8);
      fw.delete();
      for (int k = 0; k < n; k++) fw.push_back($urandom);
      send_frame(n, ($urandom_range(0, 3) == 0));
      check_writes("t6_rand");
    end

    // Reset during a write cycle kills the strobe at once.
    fw.delete();
    for (int k = 0; k < 3; k++) fw.push_back($urandom);
    send_byte(8'hA5); send_byte(8'h03);
    for (int k = 0; k < 4; k++) send_byte(8'(fw[0] >> (8 * k)));
    exp_addr.push_back(8'h00); exp_data.push_back(fw[0]);
    check("t6_we_in_write_cycle", {31'd0, bus.imem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_we_killed", {31'd0, bus.imem_we}, 32'd0);
    check("t6_ready_after_kill", {31'd0, bus.rx_ready}, 32'd1);
    check("t6_cpu_reset_kill", {31'd0, bus.cpu_reset}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset after 6 data bytes: partial word discarded, trailing bytes ignored.
    send_byte(8'hA5); send_byte(8'h02);
    for (int k = 0; k < 4; k++) send_byte(8'(fw[1] >> (8 * k)));
    exp_addr.push_back(8'h00); exp_data.push_back(fw[1]);
    send_byte(8'($urandom)); send_byte(8'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b);
    end
    repeat (5) @(negedge clk);
    check("t6_cpu_reset_held", {31'd0, bus.cpu_reset}, 32'd1);
    check("t6_done_low", {31'd0, bus.done}, 32'd0);
    check_writes("t6_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
